// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared definitions for the data-cache miss controller: the miss-sequencing
// state encoding and helpers that split a byte address into tag/set/offset.
package dcache_miss_ctrl_pkg;

  // Default cache geometry; the controller parameters start from these.
  localparam int DEF_NUM_SET      = 4;
  localparam int DEF_WAYS_PER_SET = 4;
  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_LINE_W       = 128;

  // Miss sequence: pick a victim, optionally write it back, fetch the new line,
  // install it into the arrays, then refresh the LRU.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VICTIM  = 3'd1,
    ST_WB_REQ  = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_INSTALL = 3'd5,
    ST_LRU_UPD = 3'd6
  } dcache_miss_state_t;

  // Byte-offset width within a line of line_w bits.
  function automatic int offset_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  // Tag width: whatever is left of the address above the set index and offset.
  function automatic int tag_w(input int addr_w, input int num_set, input int line_w);
    return addr_w - $clog2(num_set) - offset_w(line_w);
  endfunction

endpackage

// File: rtl/dcache_miss_ctrl.sv
// Data-cache line-miss sequencer. Accepts one miss at a time, asks the LRU for
// a victim, writes the victim back when it is valid and dirty, reads the new
// line, installs it into the tag/data arrays and finally updates the LRU. The
// LRU has one update port, shared between pipeline hits and the fill; the fill
// wins only in its single LRU_UPD cycle.
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int NUM_SET        = DEF_NUM_SET,
  parameter int WAYS_PER_SET   = DEF_WAYS_PER_SET,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int LINE_W         = DEF_LINE_W,
  parameter int NUM_SET_W      = $clog2(NUM_SET),
  parameter int WAYS_PER_SET_W = $clog2(WAYS_PER_SET),
  parameter int OFFSET_W       = offset_w(LINE_W),
  parameter int TAG_W          = ADDR_W - NUM_SET_W - OFFSET_W
) (
  input  logic                      clock,
  input  logic                      reset,
  // pipeline miss interface
  input  logic                      miss_req,
  input  logic [ADDR_W-1:0]         miss_addr,
  output logic                      miss_ready,
  output logic                      fill_done,
  output logic [WAYS_PER_SET_W-1:0] fill_way,
  // pipeline hit-update interface
  input  logic                      hit_upd_req,
  input  logic [NUM_SET_W-1:0]      hit_upd_set,
  input  logic [WAYS_PER_SET_W-1:0] hit_upd_way,
  output logic                      hit_upd_ready,
  // LRU interface
  output logic                      lru_victim_req,
  output logic [NUM_SET_W-1:0]      lru_victim_set,
  input  logic [WAYS_PER_SET_W-1:0] lru_victim_way,
  output logic                      lru_update_req,
  output logic [NUM_SET_W-1:0]      lru_update_set,
  output logic [WAYS_PER_SET_W-1:0] lru_update_way,
  // tag/data array read (victim) and write (fill)
  input  logic                      vic_valid,
  input  logic                      vic_dirty,
  input  logic [TAG_W-1:0]          vic_tag,
  input  logic [LINE_W-1:0]         vic_data,
  output logic                      arr_we,
  output logic [NUM_SET_W-1:0]      arr_set,
  output logic [WAYS_PER_SET_W-1:0] arr_way,
  output logic [TAG_W-1:0]          arr_tag,
  output logic [LINE_W-1:0]         arr_data,
  // memory request/response
  output logic                      mem_req_valid,
  output logic                      mem_req_we,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic [LINE_W-1:0]         mem_req_data,
  input  logic                      mem_req_ready,
  input  logic                      mem_rsp_valid,
  input  logic [LINE_W-1:0]         mem_rsp_data
);

  dcache_miss_state_t state_reg, state_next;

  // Captured miss context. line_reg holds the victim line until the writeback
  // is accepted and is then reused for the fetched line: the writeback always
  // completes before the read is even issued, so the two never overlap.
  logic [NUM_SET_W-1:0]      set_reg;
  logic [TAG_W-1:0]          tag_reg;
  logic [WAYS_PER_SET_W-1:0] way_reg;
  logic [TAG_W-1:0]          vtag_reg;
  logic [LINE_W-1:0]         line_reg;

  logic accept;
  assign accept = (state_reg == ST_IDLE) && miss_req;

  // State register; reset abandons any miss in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Miss-context capture: set/tag at accept, victim info in VICTIM, fill data
  // when the read response arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      set_reg  <= '0;
      tag_reg  <= '0;
      way_reg  <= '0;
      vtag_reg <= '0;
      line_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            set_reg <= miss_addr[OFFSET_W +: NUM_SET_W];
            tag_reg <= miss_addr[ADDR_W-1 -: TAG_W];
          end
        end
        ST_VICTIM: begin
          way_reg  <= lru_victim_way;
          vtag_reg <= vic_tag;
          line_reg <= vic_data;
        end
        ST_RD_WAIT: begin
          if (mem_rsp_valid) begin
            line_reg <= mem_rsp_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and all outputs; every output is defaulted first and the hit
  // path owns the LRU update port except during LRU_UPD.
  always_comb begin
    state_next     = state_reg;
    miss_ready     = 1'b0;
    fill_done      = 1'b0;
    fill_way       = '0;
    hit_upd_ready  = hit_upd_req;
    lru_victim_req = 1'b0;
    lru_victim_set = '0;
    lru_update_req = hit_upd_req;
    lru_update_set = hit_upd_set;
    lru_update_way = hit_upd_way;
    arr_we         = 1'b0;
    arr_set        = '0;
    arr_way        = '0;
    arr_tag        = '0;
    arr_data       = '0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_data   = '0;

    case (state_reg)
      ST_IDLE: begin
        miss_ready = 1'b1;
        if (accept) begin
          state_next = ST_VICTIM;
        end
      end
      ST_VICTIM: begin
        lru_victim_req = 1'b1;
        lru_victim_set = set_reg;
        state_next     = (vic_valid && vic_dirty) ? ST_WB_REQ : ST_RD_REQ;
      end
      ST_WB_REQ: begin
        // All request fields come from registers, so they stay stable while
        // the memory holds off.
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {vtag_reg, set_reg, {OFFSET_W{1'b0}}};
        mem_req_data  = line_reg;
        if (mem_req_ready) begin
          state_next = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag_reg, set_reg, {OFFSET_W{1'b0}}};
        if (mem_req_ready) begin
          state_next = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (mem_rsp_valid) begin
          state_next = ST_INSTALL;
        end
      end
      ST_INSTALL: begin
        arr_we     = 1'b1;
        arr_set    = set_reg;
        arr_way    = way_reg;
        arr_tag    = tag_reg;
        arr_data   = line_reg;
        state_next = ST_LRU_UPD;
      end
      ST_LRU_UPD: begin
        // The fill takes the LRU port; a concurrent hit is stalled a cycle.
        hit_upd_ready  = 1'b0;
        lru_update_req = 1'b1;
        lru_update_set = set_reg;
        lru_update_way = way_reg;
        fill_done      = 1'b1;
        fill_way       = way_reg;
        state_next     = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: clean miss latency, dirty writeback with
// backpressure, busy rejection, LRU-port arbitration and mid-miss reset.
module tb_dcache_miss_ctrl;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int SET_W  = 2;
  localparam int WAY_W  = 2;
  localparam int TAG_W  = 26;

  logic              clock = 1'b0;
  logic              reset;
  logic              miss_req;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_ready;
  logic              fill_done;
  logic [WAY_W-1:0]  fill_way;
  logic              hit_upd_req;
  logic [SET_W-1:0]  hit_upd_set;
  logic [WAY_W-1:0]  hit_upd_way;
  logic              hit_upd_ready;
  logic              lru_victim_req;
  logic [SET_W-1:0]  lru_victim_set;
  logic [WAY_W-1:0]  lru_victim_way;
  logic              lru_update_req;
  logic [SET_W-1:0]  lru_update_set;
  logic [WAY_W-1:0]  lru_update_way;
  logic              vic_valid;
  logic              vic_dirty;
  logic [TAG_W-1:0]  vic_tag;
  logic [LINE_W-1:0] vic_data;
  logic              arr_we;
  logic [SET_W-1:0]  arr_set;
  logic [WAY_W-1:0]  arr_way;
  logic [TAG_W-1:0]  arr_tag;
  logic [LINE_W-1:0] arr_data;
  logic              mem_req_valid;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_data;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [LINE_W-1:0] mem_rsp_data;

  int vec_cnt = 0;
  int err_cnt = 0;
  int wb_cnt  = 0;
  int rd_cnt  = 0;

  localparam logic [LINE_W-1:0] LINE_A = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [LINE_W-1:0] LINE_V = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
  localparam logic [LINE_W-1:0] LINE_B = 128'h5555_AAAA_3333_CCCC_0F0F_F0F0_1234_5678;

  dcache_miss_ctrl dut (
    .clock(clock), .reset(reset),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .fill_done(fill_done), .fill_way(fill_way),
    .hit_upd_req(hit_upd_req), .hit_upd_set(hit_upd_set), .hit_upd_way(hit_upd_way),
    .hit_upd_ready(hit_upd_ready),
    .lru_victim_req(lru_victim_req), .lru_victim_set(lru_victim_set),
    .lru_victim_way(lru_victim_way),
    .lru_update_req(lru_update_req), .lru_update_set(lru_update_set),
    .lru_update_way(lru_update_way),
    .vic_valid(vic_valid), .vic_dirty(vic_dirty), .vic_tag(vic_tag), .vic_data(vic_data),
    .arr_we(arr_we), .arr_set(arr_set), .arr_way(arr_way), .arr_tag(arr_tag),
    .arr_data(arr_data),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clock = ~clock;

  // Count accepted memory requests mid-cycle, when inputs and outputs are settled.
  always @(negedge clock) begin
    if (!reset && mem_req_valid && mem_req_ready) begin
      if (mem_req_we) wb_cnt++;
      else            rd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one clock; inputs are driven 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; miss_req = 1'b0; miss_addr = '0;
    hit_upd_req = 1'b1; hit_upd_set = 2'd2; hit_upd_way = 2'd3;
    lru_victim_way = '0; vic_valid = 1'b0; vic_dirty = 1'b0; vic_tag = '0; vic_data = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    #2;
    // reset state, including the combinational hit grant
    check("rst_miss_ready", miss_ready, 1);
    check("rst_fill_done", fill_done, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_arr_we", arr_we, 0);
    check("rst_hit_grant", hit_upd_ready, 1);
    check("rst_hit_pass_set", lru_update_set, 2);
    step();
    reset = 1'b0; hit_upd_req = 1'b0; hit_upd_set = '0; hit_upd_way = '0;
    step();

    // ---- clean miss: 0x1230 -> set 3, tag 0x48, victim way 2 ----
    miss_req = 1'b1; miss_addr = 32'h0000_1230;
    lru_victim_way = 2'd2; vic_valid = 1'b1; vic_dirty = 1'b0; vic_tag = 26'h55;
    vic_data = LINE_V; mem_req_ready = 1'b1;
    #1 check("c_accept_ready", miss_ready, 1);
    step();                                   // cycle 1: VICTIM
    miss_req = 1'b0;
    #1 check("c_victim_req", lru_victim_req, 1);
    check("c_victim_set", lru_victim_set, 3);
    check("c_busy", miss_ready, 0);
    step();                                   // cycle 2: RD_REQ
    #1 check("c_rd_valid", mem_req_valid, 1);
    check("c_rd_we", mem_req_we, 0);
    check("c_rd_addr", mem_req_addr, 32'h0000_1230);
    step();                                   // cycle 3: RD_WAIT
    mem_rsp_valid = 1'b1; mem_rsp_data = LINE_A;
    #1 check("c_wait_no_req", mem_req_valid, 0);
    step();                                   // cycle 4: INSTALL
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    #1 check("c_arr_we", arr_we, 1);
    check("c_arr_set", arr_set, 3);
    check("c_arr_way", arr_way, 2);
    check("c_arr_tag", arr_tag, 26'h48);
    check("c_arr_data", arr_data, LINE_A);
    check("c_no_early_fill", fill_done, 0);
    step();                                   // cycle 5: LRU_UPD
    #1 check("c_fill_done_cyc5", fill_done, 1);
    check("c_fill_way", fill_way, 2);
    check("c_lru_upd_req", lru_update_req, 1);
    check("c_lru_upd_set", lru_update_set, 3);
    check("c_lru_upd_way", lru_update_way, 2);
    step();                                   // IDLE
    #1 check("c_idle_ready", miss_ready, 1);
    check("c_idle_no_fill", fill_done, 0);
    check("c_wb_count", wb_cnt, 0);
    check("c_rd_count", rd_cnt, 1);

    // ---- dirty victim with backpressure: 0x4010 -> set 1, tag 0x100 ----
    miss_req = 1'b1; miss_addr = 32'h0000_4010; mem_req_ready = 1'b0;
    lru_victim_way = 2'd1; vic_valid = 1'b1; vic_dirty = 1'b1; vic_tag = 26'hABC;
    vic_data = LINE_V;
    step();                                   // VICTIM
    miss_req = 1'b0;
    #1 check("d_victim_set", lru_victim_set, 1);
    step();                                   // WB_REQ
    vic_tag = 26'h3FF_FFFF; vic_data = '1; vic_dirty = 1'b0; lru_victim_way = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("d_wb_hold_valid%0d", i), mem_req_valid, 1);
      check($sformatf("d_wb_hold_we%0d", i), mem_req_we, 1);
      check($sformatf("d_wb_hold_addr%0d", i), mem_req_addr, 32'h0002_AF10);
      check($sformatf("d_wb_hold_data%0d", i), mem_req_data, LINE_V);
      step();
    end
    mem_req_ready = 1'b1;
    #1 check("d_wb_addr_acc", mem_req_addr, 32'h0002_AF10);
    check("d_wb_we_acc", mem_req_we, 1);
    step();                                   // RD_REQ
    #1 check("d_rd_we", mem_req_we, 0);
    check("d_rd_addr", mem_req_addr, 32'h0000_4010);
    step();                                   // RD_WAIT
    check("d_wb_once", wb_cnt, 1);
    check("d_rd_count", rd_cnt, 2);
    // busy: a second miss during RD_WAIT is held off
    miss_req = 1'b1; miss_addr = 32'h0000_1230;
    #1 check("b_busy_wait", miss_ready, 0);
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data = LINE_B;
    #1 check("b_busy_wait2", miss_ready, 0);
    step();                                   // INSTALL
    mem_rsp_valid = 1'b0;
    #1 check("d_arr_way", arr_way, 1);
    check("d_arr_set", arr_set, 1);
    check("d_arr_tag", arr_tag, 26'h100);
    check("d_arr_data", arr_data, LINE_B);
    check("b_busy_install", miss_ready, 0);
    // hit arrives exactly as the fill owns the LRU port
    hit_upd_req = 1'b1; hit_upd_set = 2'd0; hit_upd_way = 2'd1;
    #1 check("a_hit_pass_install", hit_upd_ready, 1);
    step();                                   // LRU_UPD
    #1 check("a_hit_stalled", hit_upd_ready, 0);
    check("a_fill_owns_set", lru_update_set, 1);
    check("a_fill_owns_way", lru_update_way, 1);
    check("d_fill_done", fill_done, 1);
    check("b_busy_fill", miss_ready, 0);
    step();                                   // IDLE: hit granted, miss accepted
    #1 check("a_hit_granted", hit_upd_ready, 1);
    check("a_hit_upd_req", lru_update_req, 1);
    check("a_hit_upd_set", lru_update_set, 0);
    check("a_hit_upd_way", lru_update_way, 1);
    check("b_accept_after", miss_ready, 1);
    step();                                   // VICTIM of the held miss
    hit_upd_req = 1'b0; miss_req = 1'b0;
    lru_victim_way = 2'd0; vic_dirty = 1'b0;
    #1 check("b_victim_req", lru_victim_req, 1);
    check("b_victim_set", lru_victim_set, 3);
    step();                                   // RD_REQ
    step();                                   // RD_WAIT

    // ---- reset during RD_WAIT, late response must be dropped ----
    reset = 1'b1;
    #1 check("r_async_ready", miss_ready, 1);
    step();
    reset = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = LINE_A;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("r_no_arr_we%0d", i), arr_we, 0);
      check($sformatf("r_no_lru_upd%0d", i), lru_update_req, 0);
      check($sformatf("r_no_fill%0d", i), fill_done, 0);
      check($sformatf("r_idle%0d", i), miss_ready, 1);
      step();
    end
    mem_rsp_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
